// File: rtl/calc_if.sv
// calc_if: keypad, operand-memory and ALU handshake bundle for calc_ctrl.
// The slave modport is the controller side; master is the keypad/memory/ALU side.
interface calc_if;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_ready;
    logic [3:0] num;
    logic [1:0] operator;
    logic [1:0] save_enable;
    logic       clear_enable;
    logic       equ_enable;
    logic       clr_b;
    logic       alu_start;
    logic       alu_done;
    logic [2:0] state_o;
    logic       err_o;

    modport master (
        output key_valid, key_code, alu_done,
        input  key_ready, num, operator, save_enable, clear_enable,
               equ_enable, clr_b, alu_start, state_o, err_o
    );

    modport slave (
        input  key_valid, key_code, alu_done,
        output key_ready, num, operator, save_enable, clear_enable,
               equ_enable, clr_b, alu_start, state_o, err_o
    );
endinterface

// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad-driven calculator sequencer steering operand memory and ALU.
// Define CALC_CHAIN_EN to let an operator in SHOW chain the result into a new operation.
module calc_ctrl #(
    parameter int MAX_DIGITS  = 4,
    parameter int ALU_TIMEOUT = 15
) (
    input logic   clk,
    input logic   rst_n,
    calc_if.slave bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_DIGITS);
    localparam logic [TW-1:0] TMO_LAST = TW'(ALU_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        EXEC    = 3'd2,
        LOAD    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_a_q, count_a_d;
    logic [CW-1:0] count_b_q, count_b_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [3:0]    num_q, num_d;
    logic [1:0]    op_q, op_d;
    logic [1:0]    save_q, save_d;
    logic          clear_q, clear_d;
    logic          equ_q, equ_d;
    logic          clr_b_q, clr_b_d;
    logic          start_q, start_d;
    logic          ready_q, ready_d;

    logic is_digit, is_op, is_equ, is_clear, accept;

    assign is_digit = ~bus.key_code[4];
    assign is_op    = (bus.key_code[4:2] == 3'b100);
    assign is_equ   = (bus.key_code == 5'h14);
    assign is_clear = (bus.key_code == 5'h15);
    assign accept   = bus.key_valid & (ready_q | is_clear);

    // Every output is a flop; the next-state logic below computes what they show next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ENTER_A;
            count_a_q <= '0;
            count_b_q <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            num_q     <= '0;
            op_q      <= '0;
            save_q    <= '0;
            clear_q   <= 1'b0;
            equ_q     <= 1'b0;
            clr_b_q   <= 1'b0;
            start_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_a_q <= count_a_d;
            count_b_q <= count_b_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            num_q     <= num_d;
            op_q      <= op_d;
            save_q    <= save_d;
            clear_q   <= clear_d;
            equ_q     <= equ_d;
            clr_b_q   <= clr_b_d;
            start_q   <= start_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_a_d = count_a_q;
        count_b_d = count_b_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        num_d     = num_q;
        op_d      = op_q;
        save_d    = 2'b00;
        clear_d   = 1'b0;
        equ_d     = 1'b0;
        clr_b_d   = 1'b0;
        start_d   = 1'b0;

        // Clear wins over everything, including a late alu_done or a timeout.
        if (accept && is_clear) begin
            save_d    = 2'b10;
            clear_d   = 1'b1;
            count_a_d = '0;
            count_b_d = '0;
            err_d     = 1'b0;
            state_d   = ENTER_A;
        end else begin
            if (accept) begin
                err_d = 1'b0;
            end
            case (state_q)
                ENTER_A: begin
                    if (accept && is_digit && (count_a_q < MAX_CNT)) begin
                        num_d     = bus.key_code[3:0];
                        save_d    = 2'b01;
                        count_a_d = count_a_q + CW'(1);
                    end else if (accept && is_op && (count_a_q != '0)) begin
                        op_d    = bus.key_code[1:0];
                        save_d  = 2'b10;
                        state_d = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (accept && is_digit && (count_b_q < MAX_CNT)) begin
                        num_d     = bus.key_code[3:0];
                        save_d    = 2'b11;
                        count_b_d = count_b_q + CW'(1);
                    end else if (accept && is_op && (count_b_q == '0)) begin
                        op_d   = bus.key_code[1:0];
                        save_d = 2'b10;
                    end else if (accept && is_equ && (count_b_q != '0)) begin
                        start_d = 1'b1;
                        tmo_d   = '0;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    if (bus.alu_done) begin
                        save_d  = 2'b01;
                        equ_d   = 1'b1;
                        state_d = LOAD;
                    end else if (tmo_q == TMO_LAST) begin
                        save_d    = 2'b10;
                        clear_d   = 1'b1;
                        err_d     = 1'b1;
                        count_a_d = '0;
                        count_b_d = '0;
                        state_d   = ENTER_A;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                LOAD: begin
                    state_d = SHOW;
                end
                SHOW: begin
`ifdef CALC_CHAIN_EN
                    // The loaded result becomes a one-digit operand A for the next operation.
                    if (accept && is_op) begin
                        op_d      = bus.key_code[1:0];
                        save_d    = 2'b10;
                        clr_b_d   = 1'b1;
                        count_a_d = CW'(1);
                        count_b_d = '0;
                        state_d   = ENTER_B;
                    end
`else
                    state_d = SHOW;
`endif
                end
                default: begin
                    state_d = ENTER_A;
                end
            endcase
        end

        ready_d = (state_d != EXEC) && (state_d != LOAD);
    end

    assign bus.key_ready    = ready_q;
    assign bus.num          = num_q;
    assign bus.operator     = op_q;
    assign bus.save_enable  = save_q;
    assign bus.clear_enable = clear_q;
    assign bus.equ_enable   = equ_q;
    assign bus.clr_b        = clr_b_q;
    assign bus.alu_start    = start_q;
    assign bus.state_o      = state_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed scenarios plus randomized keys/alu_done checked against
// an operand-queue reference model of the calculator controller.
module tb_calc_ctrl;
    localparam int MAXD = 4;
    localparam int TMO  = 15;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    calc_if bus ();

    calc_ctrl #(.MAX_DIGITS(MAXD), .ALU_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: operands as digit queues, phase numbered by the state codes.
    int         m_phase;
    logic [3:0] a_q[$];
    logic [3:0] b_q[$];
    int         m_wait;
    logic       m_err, m_ready;
    logic [3:0] m_num;
    logic [1:0] m_op;
    logic [1:0] e_save;
    logic       e_clear, e_equ, e_start, e_clrb;

    task automatic model_step(input logic v, input logic [4:0] c, input logic d);
        logic acc;
        acc = v && (m_ready || c == 5'h15);
        e_save = 2'b00; e_clear = 0; e_equ = 0; e_start = 0; e_clrb = 0;
        if (acc && c == 5'h15) begin
            e_save = 2'b10; e_clear = 1; m_err = 0; m_phase = 0;
            a_q.delete(); b_q.delete();
        end else begin
            if (acc) m_err = 0;
            case (m_phase)
                0: if (acc) begin
                    if (c < 16) begin
                        if (a_q.size() < MAXD) begin
                            a_q.push_back(c[3:0]); m_num = c[3:0]; e_save = 2'b01;
                        end
                    end else if (c <= 19 && a_q.size() > 0) begin
                        m_op = c[1:0]; e_save = 2'b10; m_phase = 1;
                    end
                end
                1: if (acc) begin
                    if (c < 16) begin
                        if (b_q.size() < MAXD) begin
                            b_q.push_back(c[3:0]); m_num = c[3:0]; e_save = 2'b11;
                        end
                    end else if (c <= 19) begin
                        if (b_q.size() == 0) begin
                            m_op = c[1:0]; e_save = 2'b10;
                        end
                    end else if (c == 5'h14 && b_q.size() > 0) begin
                        e_start = 1; m_phase = 2; m_wait = 0;
                    end
                end
                2: begin
                    if (d) begin
                        e_save = 2'b01; e_equ = 1; m_phase = 3;
                    end else begin
                        m_wait++;
                        if (m_wait == TMO) begin
                            e_save = 2'b10; e_clear = 1; m_err = 1; m_phase = 0;
                            a_q.delete(); b_q.delete();
                        end
                    end
                end
                3: m_phase = 4;
                default: begin
`ifdef CALC_CHAIN_EN
                    if (acc && c >= 16 && c <= 19) begin
                        m_op = c[1:0]; e_save = 2'b10; e_clrb = 1; m_phase = 1;
                        a_q.delete(); a_q.push_back(4'h0); b_q.delete();
                    end
`endif
                end
            endcase
        end
        m_ready = !(m_phase == 2 || m_phase == 3);
    endtask

    task automatic press(input logic [4:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.key_valid = 0; bus.key_code = 0; bus.alu_done = 0;
        #12;
        checks++;
        if ({bus.save_enable, bus.clear_enable, bus.equ_enable, bus.clr_b, bus.alu_start, bus.err_o} !== 7'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 0", {bus.save_enable, bus.clear_enable, bus.equ_enable, bus.clr_b, bus.alu_start, bus.err_o});
        end
        checks++;
        if ({bus.num, bus.operator, bus.state_o, bus.key_ready} !== {4'h0, 2'b00, 3'd0, 1'b1}) begin
            errors++; $display("FAIL reset_state: got %b want %b", {bus.num, bus.operator, bus.state_o, bus.key_ready}, {4'h0, 2'b00, 3'd0, 1'b1});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.state_o, bus.save_enable} !== {3'd0, 2'b00}) begin
            errors++; $display("FAIL reset_release: got %b want %b", {bus.state_o, bus.save_enable}, {3'd0, 2'b00});
        end
    endtask

    task automatic test_sequence();
        press(5'h03);
        checks++;
        if ({bus.save_enable, bus.num} !== {2'b01, 4'h3}) begin
            errors++; $display("FAIL seq_digit3: got %b want %b", {bus.save_enable, bus.num}, {2'b01, 4'h3});
        end
        press(5'h07);
        checks++;
        if ({bus.save_enable, bus.num} !== {2'b01, 4'h7}) begin
            errors++; $display("FAIL seq_digit7: got %b want %b", {bus.save_enable, bus.num}, {2'b01, 4'h7});
        end
        press(5'h10);
        checks++;
        if ({bus.save_enable, bus.operator, bus.state_o} !== {2'b10, 2'b00, 3'd1}) begin
            errors++; $display("FAIL seq_op: got %b want %b", {bus.save_enable, bus.operator, bus.state_o}, {2'b10, 2'b00, 3'd1});
        end
        press(5'h02);
        checks++;
        if ({bus.save_enable, bus.num} !== {2'b11, 4'h2}) begin
            errors++; $display("FAIL seq_digitb: got %b want %b", {bus.save_enable, bus.num}, {2'b11, 4'h2});
        end
        press(5'h14);
        checks++;
        if ({bus.alu_start, bus.save_enable, bus.state_o, bus.key_ready} !== {1'b1, 2'b00, 3'd2, 1'b0}) begin
            errors++; $display("FAIL seq_start: got %b want %b", {bus.alu_start, bus.save_enable, bus.state_o, bus.key_ready}, {1'b1, 2'b00, 3'd2, 1'b0});
        end
        tick(); tick(); tick();
        checks++;
        if ({bus.alu_start, bus.state_o} !== {1'b0, 3'd2}) begin
            errors++; $display("FAIL seq_wait: got %b want %b", {bus.alu_start, bus.state_o}, {1'b0, 3'd2});
        end
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        checks++;
        if ({bus.save_enable, bus.equ_enable, bus.state_o} !== {2'b01, 1'b1, 3'd3}) begin
            errors++; $display("FAIL seq_load: got %b want %b", {bus.save_enable, bus.equ_enable, bus.state_o}, {2'b01, 1'b1, 3'd3});
        end
        tick();
        checks++;
        if ({bus.save_enable, bus.equ_enable, bus.state_o, bus.key_ready} !== {2'b00, 1'b0, 3'd4, 1'b1}) begin
            errors++; $display("FAIL seq_show: got %b want %b", {bus.save_enable, bus.equ_enable, bus.state_o, bus.key_ready}, {2'b00, 1'b0, 3'd4, 1'b1});
        end
    endtask

    task automatic test_digit_limit();
        int strobes;
        strobes = 0;
        press(5'h15);
        checks++;
        if ({bus.save_enable, bus.clear_enable, bus.state_o} !== {2'b10, 1'b1, 3'd0}) begin
            errors++; $display("FAIL limit_clear: got %b want %b", {bus.save_enable, bus.clear_enable, bus.state_o}, {2'b10, 1'b1, 3'd0});
        end
        for (int i = 0; i < 5; i++) begin
            press(5'(i + 1));
            if (bus.save_enable == 2'b01) strobes++;
        end
        checks++;
        if (strobes != 4) begin
            errors++; $display("FAIL limit_count: got %0d strobes want 4", strobes);
        end
    endtask

    task automatic test_timeout();
        press(5'h12);
        press(5'h05);
        press(5'h14);
        for (int i = 1; i < TMO; i++) tick();
        checks++;
        if ({bus.state_o, bus.save_enable} !== {3'd2, 2'b00}) begin
            errors++; $display("FAIL tmo_early: got %b want %b", {bus.state_o, bus.save_enable}, {3'd2, 2'b00});
        end
        tick();
        checks++;
        if ({bus.save_enable, bus.clear_enable, bus.err_o, bus.state_o} !== {2'b10, 1'b1, 1'b1, 3'd0}) begin
            errors++; $display("FAIL tmo_fire: got %b want %b", {bus.save_enable, bus.clear_enable, bus.err_o, bus.state_o}, {2'b10, 1'b1, 1'b1, 3'd0});
        end
        tick();
        checks++;
        if ({bus.err_o, bus.save_enable} !== {1'b1, 2'b00}) begin
            errors++; $display("FAIL tmo_sticky: got %b want %b", {bus.err_o, bus.save_enable}, {1'b1, 2'b00});
        end
        press(5'h09);
        checks++;
        if ({bus.err_o, bus.save_enable, bus.num} !== {1'b0, 2'b01, 4'h9}) begin
            errors++; $display("FAIL tmo_errclr: got %b want %b", {bus.err_o, bus.save_enable, bus.num}, {1'b0, 2'b01, 4'h9});
        end
    endtask

    task automatic test_clear_vs_done();
        press(5'h13);
        press(5'h01);
        press(5'h14);
        tick();
        bus.key_valid = 1'b1; bus.key_code = 5'h15; bus.alu_done = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        checks++;
        if ({bus.save_enable, bus.clear_enable, bus.equ_enable, bus.state_o} !== {2'b10, 1'b1, 1'b0, 3'd0}) begin
            errors++; $display("FAIL clr_prio: got %b want %b", {bus.save_enable, bus.clear_enable, bus.equ_enable, bus.state_o}, {2'b10, 1'b1, 1'b0, 3'd0});
        end
        tick();
        bus.alu_done = 1'b0;
        checks++;
        if ({bus.save_enable, bus.equ_enable, bus.state_o} !== {2'b00, 1'b0, 3'd0}) begin
            errors++; $display("FAIL clr_late_done: got %b want %b", {bus.save_enable, bus.equ_enable, bus.state_o}, {2'b00, 1'b0, 3'd0});
        end
    endtask

    task automatic test_show_operator();
        press(5'h01); press(5'h10); press(5'h02); press(5'h14);
        tick();
        bus.alu_done = 1'b1; tick(); bus.alu_done = 1'b0;
        tick();
        press(5'h05);
        press(5'h14);
        checks++;
        if ({bus.save_enable, bus.alu_start, bus.state_o} !== {2'b00, 1'b0, 3'd4}) begin
            errors++; $display("FAIL show_ignore: got %b want %b", {bus.save_enable, bus.alu_start, bus.state_o}, {2'b00, 1'b0, 3'd4});
        end
        press(5'h11);
`ifdef CALC_CHAIN_EN
        checks++;
        if ({bus.save_enable, bus.operator, bus.clr_b, bus.state_o} !== {2'b10, 2'b01, 1'b1, 3'd1}) begin
            errors++; $display("FAIL show_chain: got %b want %b", {bus.save_enable, bus.operator, bus.clr_b, bus.state_o}, {2'b10, 2'b01, 1'b1, 3'd1});
        end
`else
        checks++;
        if ({bus.save_enable, bus.clr_b, bus.state_o} !== {2'b00, 1'b0, 3'd4}) begin
            errors++; $display("FAIL show_nochain: got %b want %b", {bus.save_enable, bus.clr_b, bus.state_o}, {2'b00, 1'b0, 3'd4});
        end
`endif
    endtask

    task automatic test_reset_exec();
        press(5'h15); press(5'h04); press(5'h11); press(5'h06); press(5'h14);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.save_enable, bus.clear_enable, bus.equ_enable, bus.clr_b, bus.alu_start, bus.err_o,
             bus.num, bus.operator, bus.state_o, bus.key_ready} !== {7'b0, 4'h0, 2'b00, 3'd0, 1'b1}) begin
            errors++; $display("FAIL rst_exec: got %b want %b", {bus.save_enable, bus.clear_enable, bus.equ_enable, bus.clr_b, bus.alu_start, bus.err_o,
                bus.num, bus.operator, bus.state_o, bus.key_ready}, {7'b0, 4'h0, 2'b00, 3'd0, 1'b1});
        end
        #2 rst_n = 1'b1;
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        checks++;
        if ({bus.save_enable, bus.equ_enable, bus.state_o} !== {2'b00, 1'b0, 3'd0}) begin
            errors++; $display("FAIL rst_late_done: got %b want %b", {bus.save_enable, bus.equ_enable, bus.state_o}, {2'b00, 1'b0, 3'd0});
        end
    endtask

    task automatic test_ignored_codes();
        press(5'h08);
        for (int k = 22; k < 32; k++) begin
            press(5'(k));
            checks++;
            if ({bus.save_enable, bus.state_o} !== {2'b00, 3'd0}) begin
                errors++; $display("FAIL ignored_%0h: got %b want %b", k, {bus.save_enable, bus.state_o}, {2'b00, 3'd0});
            end
        end
    endtask

    task automatic test_random();
        logic       v, d;
        logic [4:0] c;
        int         r;
        logic [16:0] got, exp_v;
        rst_n = 1'b0; bus.key_valid = 0; bus.alu_done = 0;
        #3 rst_n = 1'b1;
        m_phase = 0; a_q.delete(); b_q.delete(); m_wait = 0;
        m_err = 0; m_ready = 1; m_num = 0; m_op = 0;
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            r = $urandom_range(0, 99);
            v = 1'($urandom_range(0, 1));
            if (r < 45)      c = 5'($urandom_range(0, 15));
            else if (r < 65) c = 5'(16 + $urandom_range(0, 3));
            else if (r < 80) c = 5'h14;
            else if (r < 86) c = 5'h15;
            else             c = 5'($urandom_range(22, 31));
            d = ($urandom_range(0, 11) == 0);
            bus.key_valid = v; bus.key_code = c; bus.alu_done = d;
            @(posedge clk);
            model_step(v, c, d);
            #1;
            got   = {bus.save_enable, bus.clear_enable, bus.equ_enable, bus.alu_start, bus.clr_b,
                     bus.state_o, bus.err_o, bus.key_ready, bus.num, bus.operator};
            exp_v = {e_save, e_clear, e_equ, e_start, e_clrb,
                     3'(m_phase), m_err, m_ready, m_num, m_op};
            checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL random_cyc%0d: got %b want %b", cyc, got, exp_v);
            end
        end
        bus.key_valid = 0; bus.alu_done = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequence();
        test_digit_limit();
        test_timeout();
        test_clear_vs_done();
        test_show_operator();
        test_reset_exec();
        test_ignored_codes();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 The block SHALL have a parameter MAX_DIGITS, default 4, giving the maximum number of nibbles accepted per operand.
REQ-002 The block SHALL have a parameter ALU_TIMEOUT, default 15, giving the maximum cycles waited for alu_done.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port key_valid, input, 1 bit: a key code is presented this cycle.
REQ-006 Port key_code, input, 5 bits: 0x00-0x0F digit; 0x10-0x13 operator (op = key_code[1:0]); 0x14 equals; 0x15 clear; other codes are ignored.
REQ-007 Port key_ready, output, 1 bit: high when non-clear keys are accepted.
REQ-008 Port num, output, 4 bits: digit value to the operand memory.
REQ-009 Port operator, output, 2 bits: operator code to the operand memory.
REQ-010 Port save_enable, output, 2 bits: 01 = operand A/result, 10 = operator, 11 = operand B, 00 = idle.
REQ-011 Port clear_enable, output, 1 bit: clear command to the memory, qualified by save_enable.
REQ-012 Port equ_enable, output, 1 bit: load the ALU result into operand A, qualified by save_enable = 01.
REQ-013 Port clr_b, output, 1 bit: one-cycle pulse that zeroes operand B.
REQ-014 Port alu_start, output, 1 bit: one-cycle pulse that starts the ALU.
REQ-015 Port alu_done, input, 1 bit: ALU result is valid.
REQ-016 Port state_o, output, 3 bits: current state code.
REQ-017 Port err_o, output, 1 bit: sticky ALU timeout flag.

Function
REQ-018 State codes SHALL be ENTER_A=0, ENTER_B=1, EXEC=2, LOAD=3, SHOW=4.
REQ-019 A key SHALL be accepted when key_valid=1 and either key_ready=1 or key_code=0x15; key_ready SHALL be 0 in EXEC and LOAD, and 1 otherwise.
REQ-020 All outputs SHALL be registered; save_enable, clear_enable, equ_enable, clr_b and alu_start SHALL be one-cycle strobes in the cycle after acceptance, and 0 otherwise.
REQ-021 ENTER_A, digit with count_a < MAX_DIGITS: num=digit, save_enable=01, count_a+1; digit at MAX_DIGITS: no strobe.
REQ-022 ENTER_A, operator with count_a >= 1: operator=op, save_enable=10, go to ENTER_B; with count_a=0: ignored.
REQ-023 ENTER_B, digit: same rule as REQ-021 using count_b and save_enable=11.
REQ-024 ENTER_B, operator with count_b=0: re-strobe save_enable=10 with the new op; with count_b>0: ignored.
REQ-025 ENTER_B, equals with count_b>=1: alu_start pulse, go to EXEC, clear the timeout counter; with count_b=0: ignored.
REQ-026 EXEC on alu_done=1: go to LOAD; LOAD SHALL strobe save_enable=01 with equ_enable=1 for exactly one cycle, then go to SHOW.
REQ-027 EXEC without alu_done for ALU_TIMEOUT cycles: strobe save_enable=10 with clear_enable=1, set err_o, go to ENTER_A.
REQ-028 Clear in any state: strobe save_enable=10 with clear_enable=1, zero both counts, go to ENTER_A. An alu_done arriving after an abort SHALL be ignored.
REQ-029 Clear SHALL have priority over alu_done and timeout in the same cycle.
REQ-030 SHOW: digit and equals keys SHALL be ignored.
REQ-031 err_o SHALL clear on the next accepted key.
REQ-032 Non-clear key codes in the range 0x16-0x1F SHALL be ignored with no strobe and no state change.

Reset
REQ-033 On rst_n=0, the block SHALL enter ENTER_A with count_a=count_b=0.
REQ-034 While rst_n=0, num, operator, save_enable, all strobes and err_o SHALL be 0, state_o SHALL be 0, and key_ready SHALL be 1.
REQ-035 Reset asserted during EXEC SHALL abandon the pending ALU result.

Configuration
REQ-036 With CALC_CHAIN_EN defined: an operator in SHOW SHALL strobe save_enable=10 with op and clr_b=1 together, set count_a=1, zero count_b, and go to ENTER_B.
REQ-037 With CALC_CHAIN_EN undefined: an operator in SHOW SHALL be ignored, and clr_b SHALL be tied to 0.

Verification
REQ-038 Keys 3, 7, 0x10, 2, 0x14, then alu_done 4 cycles later -> save_enable sequence 01, 01, 10, 11, then alu_start, then 01 with equ_enable=1, ending with state_o=4.
REQ-039 Five digits in ENTER_A with MAX_DIGITS=4 -> exactly four save_enable=01 strobes, fifth ignored.
REQ-040 Equals in EXEC with no alu_done for 15 cycles -> clear strobe, err_o=1, state_o=0; next digit -> err_o=0.
REQ-041 Clear and alu_done in the same EXEC cycle -> clear strobe, no equ_enable, state_o=0.
REQ-042 CALC_CHAIN_EN defined, key 0x11 in SHOW -> save_enable=10, operator=01, clr_b=1, state_o=1; undefined -> no strobes, state_o stays 4.
REQ-043 rst_n low mid-EXEC -> all outputs 0 immediately, state_o=0, and a later alu_done is ignored.
